// File: rtl/stats_fifo_pkg.sv
// -----------------------------------------------------------------------------
// stats_fifo_pkg
// Shared widths, types and small helpers for the statistics FIFO controller.
//   C_STATS_WIDTH : width of one statistics snapshot (one FIFO entry)
//   C_WORD_WIDTH  : width of a register-file word
//   C_NUM_WORDS   : register words per entry
//   C_OVF_WIDTH   : width of the dropped-sample counter
//   rd_state_t    : read-side sequencer states
// -----------------------------------------------------------------------------
package stats_fifo_pkg;

    localparam int C_STATS_WIDTH = 448;
    localparam int C_WORD_WIDTH  = 32;
    localparam int C_NUM_WORDS   = 14;
    localparam int C_OVF_WIDTH   = 16;
    localparam int C_IDX_WIDTH   = $clog2(C_NUM_WORDS);

    typedef logic [C_IDX_WIDTH-1:0] word_idx_t;
    typedef logic [C_OVF_WIDTH-1:0] ovf_cnt_t;

    // One FIFO entry viewed as an array of register words; word 0 is the LSBs.
    typedef logic [C_NUM_WORDS-1:0][C_WORD_WIDTH-1:0] entry_t;

    localparam word_idx_t C_LAST_IDX = word_idx_t'(C_NUM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_WAIT,
        ST_SERVE
    } rd_state_t;

    function automatic logic is_last(input word_idx_t idx);
        return idx == C_LAST_IDX;
    endfunction

endpackage

// File: rtl/stats_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// stats_fifo_ctrl_if
// Connection between the controller and the 448-bit statistics FIFO.
//   fifo_full   : FIFO full flag               (FIFO -> controller)
//   fifo_wr_en  : write strobe                 (controller -> FIFO)
//   fifo_din    : write data                   (controller -> FIFO)
//   fifo_empty  : FIFO empty flag              (FIFO -> controller)
//   fifo_rd_en  : read strobe                  (controller -> FIFO)
//   fifo_dout   : read data, valid 1 cycle after fifo_rd_en (FIFO -> controller)
//   fifo_valid  : read data valid              (FIFO -> controller)
// Modports: master = controller side, slave = FIFO side.
// -----------------------------------------------------------------------------
interface stats_fifo_ctrl_if;
    import stats_fifo_pkg::*;

    logic                     fifo_full;
    logic                     fifo_wr_en;
    logic [C_STATS_WIDTH-1:0] fifo_din;
    logic                     fifo_empty;
    logic                     fifo_rd_en;
    logic [C_STATS_WIDTH-1:0] fifo_dout;
    logic                     fifo_valid;

    modport master (
        input  fifo_full,
        input  fifo_empty,
        input  fifo_dout,
        input  fifo_valid,
        output fifo_wr_en,
        output fifo_din,
        output fifo_rd_en
    );

    modport slave (
        output fifo_full,
        output fifo_empty,
        output fifo_dout,
        output fifo_valid,
        input  fifo_wr_en,
        input  fifo_din,
        input  fifo_rd_en
    );

endinterface

// File: rtl/stats_sample_timer.sv
// -----------------------------------------------------------------------------
// stats_sample_timer
// Free-running sample timer: pulses sample_tick once every sample_period cycles
// while sampling is enabled.
//   clk           : clock
//   rst_n         : asynchronous active-low reset
//   enable        : 0 stops the timer and clears the count
//   sample_period : cycles between ticks; 0 disables sampling
//   sample_tick   : one-cycle pulse on the last cycle of each period
// -----------------------------------------------------------------------------
module stats_sample_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] sample_period,
    output logic        sample_tick
);

    logic [31:0] cnt;
    logic        active;

    assign active = enable && (sample_period != 32'd0);

    // ">=" rather than "==": when the period is shortened below the running
    // count, the timer ticks and wraps on the very next cycle instead of
    // running all the way around the 32-bit range.
    assign sample_tick = active && (cnt >= sample_period - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!active || sample_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/stats_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// stats_fifo_ctrl
// Sequences the 448-bit statistics FIFO between the stats collector and the
// AXI register file.
//   Write side: every sample tick snapshots stats_in and pushes it, or counts
//   a dropped sample if the FIFO is full.
//   Read side: pops one entry, holds it, and presents it as 14 x 32-bit words.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable         : sampling enable (write side only)
//   sample_period  : cycles between samples, 0 = no sampling
//   stats_in       : live counter vector
//   fifo           : FIFO connection (controller side)
//   word_rd_req    : one-cycle pulse consuming the current word
//   word_out       : current word of the held entry
//   word_valid     : word_out holds an unconsumed word
//   word_last      : word_out is the final word of the entry
//   overflow_clr   : pulse clearing overflow_count
//   overflow_count : saturating count of dropped samples
// -----------------------------------------------------------------------------
module stats_fifo_ctrl
    import stats_fifo_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [31:0]              sample_period,
    input  logic [C_STATS_WIDTH-1:0] stats_in,
    stats_fifo_ctrl_if.master        fifo,
    input  logic                     word_rd_req,
    output logic [C_WORD_WIDTH-1:0]  word_out,
    output logic                     word_valid,
    output logic                     word_last,
    input  logic                     overflow_clr,
    output ovf_cnt_t                 overflow_count
);

    // ---------------------------------------------------------------------
    // Write side
    // ---------------------------------------------------------------------
    logic sample_tick;
    logic drop;

    stats_sample_timer u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .sample_period (sample_period),
        .sample_tick   (sample_tick)
    );

    // Fullness is judged in the tick cycle; the write itself lands a cycle later.
    assign drop = sample_tick && fifo.fifo_full;

    // NOTE: clocked state is assigned with <= so every register samples the
    // pre-edge value of its sources, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo.fifo_wr_en <= 1'b0;
            fifo.fifo_din   <= '0;
            overflow_count  <= '0;
        end else begin
            fifo.fifo_wr_en <= sample_tick && !fifo.fifo_full;
            if (sample_tick) begin
                fifo.fifo_din <= stats_in;
            end
            // A clear coinciding with a drop keeps that drop: the count restarts at 1.
            if (overflow_clr) begin
                overflow_count <= drop ? ovf_cnt_t'(1) : '0;
            end else if (drop && (overflow_count != '1)) begin
                overflow_count <= overflow_count + ovf_cnt_t'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read side: IDLE -> POP -> WAIT -> SERVE -> IDLE
    // ---------------------------------------------------------------------
    rd_state_t state;
    word_idx_t idx;
    word_idx_t next_idx;
    entry_t    shadow;

    assign next_idx = idx + word_idx_t'(1);

    // Outputs are registered, so each transition loads the values the next
    // state presents rather than decoding them from the state afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            idx             <= '0;
            // NOTE: the wide shadow register is reset on purpose so a held
            // entry never survives a reset; data-only storage normally isn't.
            shadow          <= '0;
            fifo.fifo_rd_en <= 1'b0;
            word_out        <= '0;
            word_valid      <= 1'b0;
            word_last       <= 1'b0;
        end else begin
            fifo.fifo_rd_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo.fifo_empty) begin
                        state           <= ST_POP;
                        fifo.fifo_rd_en <= 1'b1;
                    end
                end
                ST_POP: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (fifo.fifo_valid) begin
                        state      <= ST_SERVE;
                        shadow     <= fifo.fifo_dout;
                        idx        <= '0;
                        word_out   <= fifo.fifo_dout[C_WORD_WIDTH-1:0];
                        word_valid <= 1'b1;
                        word_last  <= is_last('0);
                    end
                end
                ST_SERVE: begin
                    if (word_rd_req) begin
                        if (is_last(idx)) begin
                            state      <= ST_IDLE;
                            word_out   <= '0;
                            word_valid <= 1'b0;
                            word_last  <= 1'b0;
                        end else begin
                            idx       <= next_idx;
                            word_out  <= shadow[next_idx];
                            word_last <= is_last(next_idx);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stats_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stats_fifo_ctrl
// Directed scenarios plus a randomized run of stats_fifo_ctrl against a
// behavioural FIFO and a reference model of the sampling / word-serving rules.
// -----------------------------------------------------------------------------
module tb_stats_fifo_ctrl;
    import stats_fifo_pkg::*;

    localparam int FULL_LEVEL = 4;   // FIFO flags full at this occupancy

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         enable;
    logic [31:0]  sample_period;
    logic [447:0] stats_in;
    logic         word_rd_req;
    logic         overflow_clr;
    logic [31:0]  word_out;
    logic         word_valid;
    logic         word_last;
    logic [15:0]  overflow_count;

    stats_fifo_ctrl_if fif ();

    stats_fifo_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .sample_period  (sample_period),
        .stats_in       (stats_in),
        .fifo           (fif),
        .word_rd_req    (word_rd_req),
        .word_out       (word_out),
        .word_valid     (word_valid),
        .word_last      (word_last),
        .overflow_clr   (overflow_clr),
        .overflow_count (overflow_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [447:0] got, input logic [447:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge; outputs are read there too.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [447:0] rand_entry();
        logic [447:0] r;
        for (int j = 0; j < 14; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // Behavioural FIFO: unbounded storage, full flag at FULL_LEVEL entries,
    // read data one cycle after the read strobe.
    // ---------------------------------------------------------------------
    logic         force_full = 1'b0;
    int           fq_cnt = 0;
    logic [447:0] fq[$];

    assign fif.fifo_full  = force_full || (fq_cnt >= FULL_LEVEL);
    assign fif.fifo_empty = (fq_cnt == 0);

    initial begin : fifo_model
        logic         w;
        logic         r;
        logic [447:0] d;
        fif.fifo_dout  = '0;
        fif.fifo_valid = 1'b0;
        forever begin
            @(negedge clk);
            w = fif.fifo_wr_en;
            r = fif.fifo_rd_en;
            d = fif.fifo_din;
            @(posedge clk);
            #1;
            if (r && fq.size() > 0) begin
                fif.fifo_dout  = fq.pop_front();
                fif.fifo_valid = 1'b1;
            end else begin
                fif.fifo_valid = 1'b0;
            end
            if (w) fq.push_back(d);
            fq_cnt = fq.size();
        end
    end

    task automatic clear_fifo();
        fq.delete();
        fq_cnt = 0;
    endtask

    task automatic preload(input logic [447:0] e);
        fq.push_back(e);
        fq_cnt = fq.size();
    endtask

    int rd_pulses = 0;
    always @(negedge clk) if (rst_n) rd_pulses += int'(fif.fifo_rd_en);

    // ---------------------------------------------------------------------
    // Reference model for the randomized run, advanced once per cycle.
    // ---------------------------------------------------------------------
    logic         mon_on = 1'b0;
    logic [31:0]  m_elapsed;
    logic         m_wr;
    logic [447:0] m_din;
    int           m_ovf;
    int           m_widx;
    logic [447:0] exp_q[$];

    always @(negedge clk) begin : ref_monitor
        logic         act;
        logic         tk;
        logic         full;
        logic [447:0] ent;
        if (mon_on) begin
            check("rnd_wr_en", fif.fifo_wr_en, m_wr);
            if (m_wr) check("rnd_din", fif.fifo_din, m_din);
            check("rnd_ovf", overflow_count, m_ovf);
            if (word_valid && word_rd_req) begin
                check("rnd_entry_avail", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) begin
                    ent = exp_q[0];
                    check("rnd_word", word_out, ent[m_widx*32 +: 32]);
                    check("rnd_last", word_last, (m_widx == 13));
                    m_widx++;
                    if (m_widx == 14) begin
                        m_widx = 0;
                        void'(exp_q.pop_front());
                    end
                end
            end
            // A sample is due once `period` active cycles have elapsed since
            // the last one; a shorter new period makes it due immediately.
            act  = enable && (sample_period != 0);
            tk   = act && (m_elapsed + 1 >= sample_period);
            full = fif.fifo_full;
            m_wr = tk && !full;
            if (tk) m_din = stats_in;
            if (m_wr) exp_q.push_back(stats_in);
            if (overflow_clr) m_ovf = (tk && full) ? 1 : 0;
            else if (tk && full && m_ovf < 65535) m_ovf++;
            m_elapsed = (!act || tk) ? 32'd0 : m_elapsed + 32'd1;
        end
    end

    // ---------------------------------------------------------------------
    // Helpers for directed scenarios
    // ---------------------------------------------------------------------
    task automatic do_reset();
        rst_n         = 1'b0;
        enable        = 1'b0;
        sample_period = '0;
        stats_in      = '0;
        word_rd_req   = 1'b0;
        overflow_clr  = 1'b0;
        force_full    = 1'b0;
        step(2);
        clear_fifo();
        rst_n = 1'b1;
        step(1);
    endtask

    // Consume all 14 words of the held entry, one request per cycle.
    task automatic consume(input string tag, input logic [447:0] e);
        for (int i = 0; i < 14; i++) begin
            check({tag, "_valid"}, word_valid, 1'b1);
            check({tag, "_word"}, word_out, e[i*32 +: 32]);
            check({tag, "_last"}, word_last, (i == 13));
            word_rd_req = 1'b1;
            step(1);
        end
        word_rd_req = 1'b0;
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    logic [447:0] e0, e1, samp;

    initial begin
        enable        = 1'b0;
        sample_period = '0;
        stats_in      = '0;
        word_rd_req   = 1'b0;
        overflow_clr  = 1'b0;

        // ---- Reset state ----
        #2;
        check("rst_wr_en", fif.fifo_wr_en, 1'b0);
        check("rst_rd_en", fif.fifo_rd_en, 1'b0);
        check("rst_din", fif.fifo_din, '0);
        check("rst_word_valid", word_valid, 1'b0);
        check("rst_word_last", word_last, 1'b0);
        check("rst_word_out", word_out, '0);
        check("rst_ovf", overflow_count, '0);
        check("rst_cnt", dut.u_timer.cnt, '0);

        // ---- 1: period 4, one write every 4 cycles with the tick-cycle data ----
        do_reset();
        enable        = 1'b1;
        sample_period = 32'd4;
        for (int k = 0; k < 12; k++) begin
            samp     = rand_entry();
            stats_in = samp;
            step(1);
            check("t1_wr_en", fif.fifo_wr_en, (k % 4 == 3));
            if (k % 4 == 3) check("t1_din", fif.fifo_din, samp);
        end

        // ---- 2: drops while full, saturation, clear with concurrent drop ----
        do_reset();
        force_full    = 1'b1;
        enable        = 1'b1;
        sample_period = 32'd2;
        for (int k = 0; k < 6; k++) begin
            step(1);
            check("t2_no_wr", fif.fifo_wr_en, 1'b0);
        end
        check("t2_ovf_3", overflow_count, 16'd3);
        sample_period = 32'd1;
        step(65532);
        check("t2_ovf_max", overflow_count, 16'hFFFF);
        step(1);
        check("t2_ovf_sat", overflow_count, 16'hFFFF);
        overflow_clr = 1'b1;
        step(1);
        check("t2_clr_drop", overflow_count, 16'd1);
        enable = 1'b0;
        step(1);
        check("t2_clr_only", overflow_count, 16'd0);
        overflow_clr = 1'b0;

        // ---- 3: one entry served word by word ----
        do_reset();
        for (int k = 0; k < 14; k++) e0[k*32 +: 32] = 32'h100 + k;
        rd_pulses = 0;
        preload(e0);
        step(1);
        check("t3_pop", fif.fifo_rd_en, 1'b1);
        step(1);
        check("t3_wait_rd", fif.fifo_rd_en, 1'b0);
        check("t3_wait_valid", word_valid, 1'b0);
        step(1);
        consume("t3", e0);
        check("t3_idle_valid", word_valid, 1'b0);
        check("t3_idle_last", word_last, 1'b0);
        step(3);
        check("t3_no_extra_pop", rd_pulses, 1);
        check("t3_stay_idle", word_valid, 1'b0);

        // ---- 4: two entries, held word, 3-cycle gap, one pop per entry ----
        do_reset();
        e0 = rand_entry();
        e1 = rand_entry();
        rd_pulses = 0;
        preload(e0);
        preload(e1);
        step(1);
        check("t4_pop0", fif.fifo_rd_en, 1'b1);
        step(1);
        check("t4_wait0", word_valid, 1'b0);
        step(1);
        for (int k = 0; k < 5; k++) begin
            check("t4_hold_valid", word_valid, 1'b1);
            check("t4_hold_word", word_out, e0[31:0]);
            check("t4_hold_rd", fif.fifo_rd_en, 1'b0);
            step(1);
        end
        consume("t4_e0", e0);
        check("t4_gap_idle", word_valid, 1'b0);
        check("t4_gap_idle_rd", fif.fifo_rd_en, 1'b0);
        step(1);
        check("t4_gap_pop", fif.fifo_rd_en, 1'b1);
        check("t4_gap_pop_valid", word_valid, 1'b0);
        step(1);
        check("t4_gap_wait", word_valid, 1'b0);
        step(1);
        consume("t4_e1", e1);
        step(4);
        check("t4_pops", rd_pulses, 2);
        check("t4_drained", word_valid, 1'b0);

        // ---- 5: timer disable, period 0, re-enable, period shrink ----
        do_reset();
        enable        = 1'b1;
        sample_period = 32'd5;
        step(2);
        check("t5_cnt_run", dut.u_timer.cnt, 32'd2);
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("t5_dis_cnt", dut.u_timer.cnt, 32'd0);
            check("t5_dis_wr", fif.fifo_wr_en, 1'b0);
        end
        enable        = 1'b1;
        sample_period = 32'd0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("t5_p0_cnt", dut.u_timer.cnt, 32'd0);
            check("t5_p0_wr", fif.fifo_wr_en, 1'b0);
        end
        sample_period = 32'd2;
        step(1);
        check("t5_p2_first", fif.fifo_wr_en, 1'b0);
        check("t5_p2_cnt", dut.u_timer.cnt, 32'd1);
        step(1);
        check("t5_p2_tick", fif.fifo_wr_en, 1'b1);
        sample_period = 32'd8;
        step(5);
        check("t5_p8_cnt", dut.u_timer.cnt, 32'd5);
        check("t5_p8_wr", fif.fifo_wr_en, 1'b0);
        sample_period = 32'd3;
        step(1);
        check("t5_shrink_tick", fif.fifo_wr_en, 1'b1);
        check("t5_shrink_wrap", dut.u_timer.cnt, 32'd0);
        enable = 1'b0;

        // ---- 6: reset during SERVE at idx 5 ----
        do_reset();
        e0 = rand_entry();
        e1 = rand_entry();
        preload(e0);
        preload(e1);
        step(3);
        word_rd_req = 1'b1;
        step(5);
        word_rd_req = 1'b0;
        check("t6_idx5_word", word_out, e0[5*32 +: 32]);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", word_valid, 1'b0);
        check("t6_rst_word", word_out, '0);
        check("t6_rst_last", word_last, 1'b0);
        check("t6_rst_rd", fif.fifo_rd_en, 1'b0);
        check("t6_rst_wr", fif.fifo_wr_en, 1'b0);
        check("t6_rst_ovf", overflow_count, '0);
        step(2);
        rst_n = 1'b1;
        check("t6_rel_idle_rd", fif.fifo_rd_en, 1'b0);
        step(1);
        check("t6_rel_pop", fif.fifo_rd_en, 1'b1);
        step(1);
        check("t6_rel_wait", word_valid, 1'b0);
        step(1);
        check("t6_rel_serve", word_valid, 1'b1);
        check("t6_rel_word", word_out, e1[31:0]);

        // ---- 7: randomized run against the reference model ----
        do_reset();
        m_elapsed = '0;
        m_wr      = 1'b0;
        m_din     = '0;
        m_ovf     = 0;
        m_widx    = 0;
        exp_q.delete();
        enable        = 1'b1;
        sample_period = 32'd3;
        mon_on        = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 49) == 0) sample_period = $urandom_range(0, 6);
            if ($urandom_range(0, 29) == 0) enable = ~enable;
            stats_in     = rand_entry();
            force_full   = ($urandom_range(0, 9) == 0);
            overflow_clr = ($urandom_range(0, 39) == 0);
            word_rd_req  = 1'($urandom_range(0, 1));
            step(1);
        end
        mon_on       = 1'b0;
        word_rd_req  = 1'b0;
        overflow_clr = 1'b0;
        enable       = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
